// File: rtl/aes_pkg.sv
// Shared AES state helpers: per-NB row-offset table, byte placement and state typedefs.
// Used by shift_rows_perm and shift_rows_pipe.
package aes_pkg;

    typedef logic [32*4-1:0] state_nb4_t;
    typedef logic [32*6-1:0] state_nb6_t;
    typedef logic [32*8-1:0] state_nb8_t;

    // One 16-bit entry per legal NB (index 0: NB=4, 1: NB=6, 2: NB=8).
    // Nibble r of an entry is the left-rotate amount for row r.
    localparam logic [2:0][15:0] ROW_OFF_TBL = {16'h4310, 16'h3210, 16'h3210};

    function automatic int row_offset(input int nb, input int r);
        logic [15:0] entry;
        entry = ROW_OFF_TBL[(nb - 4) / 2];
        return int'(entry[4*r +: 4]);
    endfunction

    // LSB position of byte (r,c) in a column-major state of nb columns.
    function automatic int byte_lsb(input int nb, input int r, input int c);
        return 32*nb - 8 - 8*(4*c + r);
    endfunction

    // Column of the input state that supplies output byte (r,c).
    function automatic int src_col(input int nb, input int r, input int c, input bit inv);
        int off;
        off = row_offset(nb, r);
        if (inv)
            return (c + nb - off) % nb;
        return (c + off) % nb;
    endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for shift_rows_pipe: input stream, output stream and mode bits.
// slave = the pipe itself, master = whatever drives and drains it.
interface shift_rows_pipe_if #(
    parameter int NB = 4
);
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_inv;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv
    );

endinterface

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation for an NB-column state.
// The inverse path and its inv port exist only when SHIFT_ROWS_PIPE_INV_EN is defined.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] in_data,
`ifdef SHIFT_ROWS_PIPE_INV_EN
    input  logic             inv,
`endif
    output logic [32*NB-1:0] out_data
);

    // Pure wiring: every output byte picks a fixed source byte, or one of two when inverse is built.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int DST = byte_lsb(NB, r, c);
            localparam int FWD = byte_lsb(NB, r, src_col(NB, r, c, 1'b0));
`ifdef SHIFT_ROWS_PIPE_INV_EN
            localparam int INV = byte_lsb(NB, r, src_col(NB, r, c, 1'b1));
            assign out_data[DST +: 8] = inv ? in_data[INV +: 8] : in_data[FWD +: 8];
`else
            assign out_data[DST +: 8] = in_data[FWD +: 8];
`endif
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage with a registered main slot plus skid slot; one-cycle latency, full rate.
// Define SHIFT_ROWS_PIPE_INV_EN to build the per-transaction InvShiftRows path.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_rows_pipe_if.slave bus
);

    localparam int W = 32 * NB;

    logic [W-1:0] perm_data;
    logic         perm_inv;

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         main_inv;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         skid_inv;

    logic         in_ready;
    logic         accept;
    logic         consume;

`ifdef SHIFT_ROWS_PIPE_INV_EN
    shift_rows_perm #(.NB(NB)) u_perm (
        .in_data  (bus.in_data),
        .inv      (bus.in_inv),
        .out_data (perm_data)
    );
    assign perm_inv = bus.in_inv;
`else
    logic unused_in_inv;

    shift_rows_perm #(.NB(NB)) u_perm (
        .in_data  (bus.in_data),
        .out_data (perm_data)
    );
    assign unused_in_inv = bus.in_inv;
    assign perm_inv      = 1'b0;
`endif

    // Ready depends only on the skid flag, so downstream stalls never reach upstream combinationally.
    assign in_ready  = !skid_valid && !rst;
    assign accept    = bus.in_valid && in_ready;
    assign consume   = main_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_inv   = main_inv;

    // Main refills from skid first to preserve order; new data lands in skid only while main stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_inv   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_inv   <= 1'b0;
        end else begin
            if (!main_valid || consume) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    main_inv   <= skid_inv;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= accept;
                    if (accept) begin
                        main_data <= perm_data;
                        main_inv  <= perm_inv;
                    end
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= perm_data;
                skid_inv   <= perm_inv;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Randomised self-checking bench for shift_rows_pipe (NB=4 and NB=8 instances) against a row-rotation model.
// Expectations follow SHIFT_ROWS_PIPE_INV_EN: without it every block is expected forward with out_inv=0.
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_PIPE_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    logic [127:0] exp_q[$];
    logic         exp_inv_q[$];

    always #5 clk = ~clk;

    shift_rows_pipe_if #(.NB(4)) b4 ();
    shift_rows_pipe_if #(.NB(8)) b8 ();

    shift_rows_pipe #(.NB(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    shift_rows_pipe #(.NB(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each row is a list of nb bytes rotated left (forward) or right (inverse).
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] s, input bit inv);
        logic [7:0]   row [8];
        logic [255:0] o;
        int           off;
        int           w;
        int           k;
        o = '0;
        w = 32 * nb;
        for (int r = 0; r < 4; r++) begin
            off = (r < 2) ? r : ((nb == 8) ? r + 1 : r);
            for (int c = 0; c < nb; c++) row[c] = s[w-1-8*(4*c+r) -: 8];
            for (int c = 0; c < nb; c++) begin
                k = inv ? (c + nb - off) % nb : (c + off) % nb;
                o[w-1-8*(4*c+r) -: 8] = row[k];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref4(input logic [127:0] s, input bit inv);
        logic [255:0] t;
        t = ref_shift(4, {128'd0, s}, inv && INV_EN);
        return t[127:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        b4.in_valid = 1'b1;
        b4.in_data = rand128();
        b4.in_inv = 1'b0;
        b4.out_ready = 1'b1;
        b8.in_valid = 1'b0;
        b8.in_data = '0;
        b8.in_inv = 1'b0;
        b8.out_ready = 1'b1;
        tick();
        tick();
        total++; if (b4.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b, expected 0", b4.in_ready); else passed++;
        total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", b4.out_valid); else passed++;
        total++; if (b4.out_data !== 128'd0) $display("[TB] FAIL reset_out_data: got %h, expected 0", b4.out_data); else passed++;
        total++; if (b4.out_inv !== 1'b0) $display("[TB] FAIL reset_out_inv: got %b, expected 0", b4.out_inv); else passed++;
        total++; if (b8.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid8: got %b, expected 0", b8.out_valid); else passed++;
        rst = 1'b0;
        b4.in_valid = 1'b0;
        #1;
        total++; if (b4.in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b, expected 1", b4.in_ready); else passed++;
        tick();
        total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL release_no_output: got %b, expected 0", b4.out_valid); else passed++;
    endtask

    task automatic test_known_vectors();
        logic [127:0] vin  [3];
        logic [127:0] vexp [3];
        bit           vinv [3];
        vin[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        vexp[0] = 128'h00050a0f04090e03080d02070c01060b;
        vinv[0] = 1'b0;
        vin[1]  = 128'hd42711aee0bf98f1b8b45de51e415230;
        vexp[1] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vinv[1] = 1'b0;
        vin[2]  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vexp[2] = INV_EN ? 128'hd42711aee0bf98f1b8b45de51e415230 : ref4(vin[2], 1'b0);
        vinv[2] = 1'b1;
        b4.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b4.in_valid = 1'b1;
            b4.in_data = vin[i];
            b4.in_inv = vinv[i];
            tick();
            b4.in_valid = 1'b0;
            total++; if (b4.out_valid !== 1'b1) $display("[TB] FAIL vec%0d_valid: got %b, expected 1", i, b4.out_valid); else passed++;
            total++; if (b4.out_data !== vexp[i]) $display("[TB] FAIL vec%0d_data: got %h, expected %h", i, b4.out_data, vexp[i]); else passed++;
            total++; if (b4.out_inv !== (vinv[i] && INV_EN)) $display("[TB] FAIL vec%0d_inv: got %b, expected %b", i, b4.out_inv, vinv[i] && INV_EN); else passed++;
            tick();
            total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL vec%0d_drained: got %b, expected 0", i, b4.out_valid); else passed++;
        end
    endtask

    task automatic test_nb8();
        logic [255:0] v;
        logic [255:0] fwd;
        logic [255:0] want;
        logic [255:0] got;
        for (int k = 0; k < 32; k++) v[255-8*k -: 8] = k[7:0];
        fwd = ref_shift(8, v, 1'b0);
        b8.out_ready = 1'b1;
        b8.in_valid = 1'b1;
        b8.in_data = v;
        b8.in_inv = 1'b0;
        tick();
        got = b8.out_data;
        total++; if (b8.out_valid !== 1'b1) $display("[TB] FAIL nb8_valid: got %b, expected 1", b8.out_valid); else passed++;
        total++; if (got[231:224] !== 8'h13) $display("[TB] FAIL nb8_byte_r3c0: got %h, expected 13", got[231:224]); else passed++;
        total++; if (got[239:232] !== 8'h0e) $display("[TB] FAIL nb8_byte_r2c0: got %h, expected 0e", got[239:232]); else passed++;
        total++; if (got !== fwd) $display("[TB] FAIL nb8_fwd: got %h, expected %h", got, fwd); else passed++;
        b8.in_data = fwd;
        b8.in_inv = 1'b1;
        want = INV_EN ? v : ref_shift(8, fwd, 1'b0);
        tick();
        b8.in_valid = 1'b0;
        total++; if (b8.out_data !== want) $display("[TB] FAIL nb8_inv: got %h, expected %h", b8.out_data, want); else passed++;
        total++; if (b8.out_inv !== INV_EN) $display("[TB] FAIL nb8_inv_flag: got %b, expected %b", b8.out_inv, INV_EN); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, c;
        bit           ia, ib, ic;
        a = rand128(); b = rand128(); c = rand128();
        ia = 1'($urandom); ib = 1'($urandom); ic = 1'($urandom);
        b4.out_ready = 1'b0;
        b4.in_valid = 1'b1;
        b4.in_data = a;
        b4.in_inv = ia;
        total++; if (b4.in_ready !== 1'b1) $display("[TB] FAIL bp_ready_a: got %b, expected 1", b4.in_ready); else passed++;
        tick();
        b4.in_data = b;
        b4.in_inv = ib;
        total++; if (b4.in_ready !== 1'b1) $display("[TB] FAIL bp_ready_b: got %b, expected 1", b4.in_ready); else passed++;
        total++; if (b4.out_data !== ref4(a, ia)) $display("[TB] FAIL bp_main_a: got %h, expected %h", b4.out_data, ref4(a, ia)); else passed++;
        tick();
        b4.in_data = c;
        b4.in_inv = ic;
        for (int n = 0; n < 2; n++) begin
            total++; if (b4.in_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready%0d: got %b, expected 0", n, b4.in_ready); else passed++;
            total++; if (b4.out_valid !== 1'b1 || b4.out_data !== ref4(a, ia)) $display("[TB] FAIL bp_hold_a%0d: got %b/%h, expected 1/%h", n, b4.out_valid, b4.out_data, ref4(a, ia)); else passed++;
            total++; if (b4.out_inv !== (ia && INV_EN)) $display("[TB] FAIL bp_hold_inv%0d: got %b, expected %b", n, b4.out_inv, ia && INV_EN); else passed++;
            tick();
        end
        b4.out_ready = 1'b1;
        tick();
        total++; if (b4.out_valid !== 1'b1 || b4.out_data !== ref4(b, ib)) $display("[TB] FAIL bp_out_b: got %b/%h, expected 1/%h", b4.out_valid, b4.out_data, ref4(b, ib)); else passed++;
        total++; if (b4.in_ready !== 1'b1) $display("[TB] FAIL bp_ready_c: got %b, expected 1", b4.in_ready); else passed++;
        tick();
        b4.in_valid = 1'b0;
        total++; if (b4.out_valid !== 1'b1 || b4.out_data !== ref4(c, ic)) $display("[TB] FAIL bp_out_c: got %b/%h, expected 1/%h", b4.out_valid, b4.out_data, ref4(c, ic)); else passed++;
        total++; if (b4.out_inv !== (ic && INV_EN)) $display("[TB] FAIL bp_inv_c: got %b, expected %b", b4.out_inv, ic && INV_EN); else passed++;
        tick();
        total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL bp_empty: got %b, expected 0", b4.out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = rand128();
        b4.out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                b4.in_valid = 1'b1;
                b4.in_data = d[i];
                b4.in_inv = i[0];
                total++; if (b4.in_ready !== 1'b1) $display("[TB] FAIL b2b_ready%0d: got %b, expected 1", i, b4.in_ready); else passed++;
            end else begin
                b4.in_valid = 1'b0;
            end
            if (i > 0) begin
                total++; if (b4.out_valid !== 1'b1 || b4.out_data !== ref4(d[i-1], 1'((i-1) % 2))) $display("[TB] FAIL b2b_data%0d: got %b/%h, expected 1/%h", i-1, b4.out_valid, b4.out_data, ref4(d[i-1], 1'((i-1) % 2))); else passed++;
                total++; if (b4.out_inv !== (1'((i-1) % 2) && INV_EN)) $display("[TB] FAIL b2b_inv%0d: got %b, expected %b", i-1, b4.out_inv, 1'((i-1) % 2) && INV_EN); else passed++;
            end
            tick();
        end
        total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL b2b_empty: got %b, expected 0", b4.out_valid); else passed++;
    endtask

    task automatic test_random_stream();
        bit           hold = 1'b0;
        logic [127:0] hd = '0;
        logic         hi = 1'b0;
        bit           acc, cons;
        for (int cyc = 0; cyc < 300; cyc++) begin
            b4.in_valid = ($urandom_range(0, 3) != 0);
            b4.in_data = rand128();
            b4.in_inv = 1'($urandom);
            b4.out_ready = ($urandom_range(0, 3) != 0);
            if (hold) begin
                total++; if (b4.out_valid !== 1'b1 || b4.out_data !== hd || b4.out_inv !== hi) $display("[TB] FAIL rnd_stable@%0d: got %b/%h/%b, expected 1/%h/%b", cyc, b4.out_valid, b4.out_data, b4.out_inv, hd, hi); else passed++;
            end
            acc = b4.in_valid && b4.in_ready;
            cons = b4.out_valid && b4.out_ready;
            if (cons) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL rnd_extra@%0d: got block %h, expected none", cyc, b4.out_data);
                end else if (b4.out_data !== exp_q[0] || b4.out_inv !== exp_inv_q[0]) begin
                    $display("[TB] FAIL rnd_data@%0d: got %h/%b, expected %h/%b", cyc, b4.out_data, b4.out_inv, exp_q[0], exp_inv_q[0]);
                end else begin
                    passed++;
                end
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_inv_q.pop_front());
                end
            end
            if (acc) begin
                exp_q.push_back(ref4(b4.in_data, b4.in_inv));
                exp_inv_q.push_back(b4.in_inv && INV_EN);
            end
            hold = b4.out_valid && !b4.out_ready;
            hd = b4.out_data;
            hi = b4.out_inv;
            tick();
        end
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
            if (b4.out_valid) begin
                total++; if (b4.out_data !== exp_q[0] || b4.out_inv !== exp_inv_q[0]) $display("[TB] FAIL rnd_drain%0d: got %h/%b, expected %h/%b", n, b4.out_data, b4.out_inv, exp_q[0], exp_inv_q[0]); else passed++;
                void'(exp_q.pop_front());
                void'(exp_inv_q.pop_front());
            end
            tick();
        end
        total++; if (exp_q.size() != 0) $display("[TB] FAIL rnd_lost: got %0d blocks outstanding, expected 0", exp_q.size()); else passed++;
        total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL rnd_empty: got %b, expected 0", b4.out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        b4.out_ready = 1'b0;
        b4.in_valid = 1'b1;
        b4.in_data = rand128();
        b4.in_inv = 1'b1;
        tick();
        b4.in_data = rand128();
        tick();
        b4.in_valid = 1'b0;
        total++; if (b4.in_ready !== 1'b0) $display("[TB] FAIL rstmid_full: got %b, expected 0", b4.in_ready); else passed++;
        rst = 1'b1;
        #1;
        total++; if (b4.in_ready !== 1'b0) $display("[TB] FAIL rstmid_ready_in_rst: got %b, expected 0", b4.in_ready); else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL rstmid_valid: got %b, expected 0", b4.out_valid); else passed++;
        total++; if (b4.out_data !== 128'd0) $display("[TB] FAIL rstmid_data: got %h, expected 0", b4.out_data); else passed++;
        total++; if (b4.in_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b, expected 1", b4.in_ready); else passed++;
        b4.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++; if (b4.out_valid !== 1'b0) $display("[TB] FAIL rstmid_stale%0d: got %b, expected 0", n, b4.out_valid); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_nb8();
        test_backpressure();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
- REQ-001: Parameter NB, default 4, meaning state columns (Rijndael Nb); legal values 4, 6, 8.
- REQ-002: Derived localparam W = 32*NB, meaning state width in bits; not overridable.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: in_valid  input  1  upstream block present.
- REQ-006: in_ready  output  1  block accepts input this cycle.
- REQ-007: in_data  input  W  state, column-major; byte (r,c) at bits [W-1-8*(4c+r) -: 8].
- REQ-008: in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data.
- REQ-009: out_valid  output  1  result present.
- REQ-010: out_ready  input  1  downstream accepts.
- REQ-011: out_data  output  W  permuted state, same byte layout.
- REQ-012: out_inv  output  1  in_inv of the transaction on out_data.

Function
- REQ-013: Row offsets: NB=4 or 6 -> {0,1,2,3}; NB=8 -> {0,1,3,4}, in a constant table.
- REQ-014: Forward: out(r,c) = in(r,(c+off[r]) mod NB); inverse: out(r,c) = in(r,(c-off[r]) mod NB).
- REQ-015: Permutation is combinational on the input side; the result is registered; latency exactly 1 cycle from accept to out_valid.
- REQ-016: Transfer on a port occurs when valid and ready are both high on a rising edge.
- REQ-017: Output stage is a main register plus one skid register (2 entries total).
- REQ-018: in_ready = !skid_valid && !rst; it is registered-state-derived and has no combinational path from out_ready.
- REQ-019: Main empty or consumed this cycle: accepted data loads main; otherwise accepted data loads skid.
- REQ-020: Main consumed while skid full: skid moves to main, skid empties.
- REQ-021: Simultaneous accept and consume with main full and skid empty: new data loads main; out_valid stays high.
- REQ-022: Full throughput: with out_ready held high, one block per cycle, no bubbles.
- REQ-023: Output order equals input order; no drop, no duplication.
- REQ-024: out_data and out_inv hold stable while out_valid && !out_ready.
- REQ-025: Per-transaction mode: consecutive blocks may alternate in_inv without a bubble.

Reset
- REQ-026: Reset values: out_valid=0, out_data=0, out_inv=0, skid_valid=0, skid data=0.
- REQ-027: in_ready is 0 during any cycle with rst=1, and 1 on the first cycle after release.
- REQ-028: Reset mid-operation discards main and skid contents; no transfer is completed on the reset edge.

Configuration
- REQ-029: Macro SHIFT_ROWS_PIPE_INV_EN defined: the inverse path is built per REQ-014.
- REQ-030: Macro undefined: in_inv is ignored, forward only, out_inv is constant 0, and no inverse mux logic is synthesised.

Structure
- REQ-031: Shared package aes_pkg holds the NB-indexed row-offset table, the byte-index function (r,c)->bit position, and a state typedef by NB.
- REQ-032: One sub-module, shift_rows_perm: parametrised combinational permute (NB, inv); the top holds only the handshake and registers.

Verification
- REQ-033: NB=4, fwd, in_data=000102..0f, out_ready=1 -> one cycle later out_data=00050a0f04090e03080d02070c01060b, out_inv=0.
- REQ-034: NB=4, fwd, in=d42711aee0bf98f1b8b45de51e415230 -> out=d4bf5d30e0b452aeb84111f11e2798e5 (FIPS-197 App. B round 1); same vector inv back -> original.
- REQ-035: NB=8, fwd, in=bytes 00..1f -> out(3,0)=in(3,4)=0x13, out(2,0)=in(2,3)=0x0e; inv of result returns 00..1f.
- REQ-036: Backpressure: 3 blocks A,B,C offered back-to-back, out_ready=0 -> A in main, B in skid, in_ready=0 with C held; out_ready=1 -> A,B,C emitted in order on consecutive cycles.
- REQ-037: Alternating in_inv 0,1,0,1 at full rate -> each out_inv matches its transaction, no bubbles.
- REQ-038: rst pulsed with main and skid full -> next cycle out_valid=0, in_ready=1, no stale block emitted; without SHIFT_ROWS_PIPE_INV_EN, in_inv=1 still yields the forward result.
